rhopi_inv_stream: RTL
=====================

Name: rhopi_inv_stream

Overview:
- Lane-serial inverse of the Keccak rho+pi step; the decoder counterpart of the combinational RhoPi block.
- Accepts a 25-lane, 64-bit Keccak state one lane per beat and buffers it.
- Applies inverse pi, then inverse rho (rotate right by the rho offset), and streams the restored state out one lane per beat.
- Used by the SHA3 bench and debug path to undo RhoPi; INVERSE=0 gives a forward mode for round-trip checks.

Parameters:
- LANE_W, 64, lane width. Only 64 is supported; the rho offsets are defined mod 64.
- INVERSE, 1. 1 = inverse rho-pi; 0 = forward rho-pi, bit-exact with RhoPi.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- s_valid  in  1  input lane valid.
- s_ready  out  1  block can accept an input lane.
- s_data  in  64  input lane; beat k carries lane index k = x+5y, k = 0..24.
- s_last  in  1  sender marks lane 24.
- m_valid  out  1  output lane valid.
- m_ready  in  1  downstream accepts the output lane.
- m_data  out  64  output lane; beat k carries lane index k.
- m_last  out  1  high with output lane 24.
- busy  out  1  high in XFORM or SEND.
- frame_err  out  1  one-cycle pulse when s_last disagrees with the lane count.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=LOAD; in_cnt=0; out_cnt=0; both 25x64 buffers cleared.
  - s_ready=1, m_valid=0, m_data=0, m_last=0, busy=0, frame_err=0.
  - Reset applies mid-frame in any state; the partial frame is discarded.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready: in_buf[in_cnt]<=s_data and in_cnt increments.
  - Lane 24 accepted: in_cnt wraps to 0 and the state goes to XFORM.
- XFORM (exactly 1 cycle):
  - s_ready=0, busy=1.
  - out_buf <= transform(in_buf), registered in one cycle.
  - Next state is SEND.
- SEND:
  - m_valid=1, m_data=out_buf[out_cnt], m_last=(out_cnt==24), s_ready=0, busy=1.
  - On m_valid&&m_ready: out_cnt increments.
  - Lane 24 accepted: out_cnt wraps to 0 and the state goes to LOAD. s_ready rises the next cycle; there is no input/output overlap.
  - m_data and m_last stay stable while m_valid&&!m_ready.
- Latency:
  - The first output beat is valid 2 cycles after the edge that accepts input lane 24.
  - Full frame minimum: 25 input + 1 transform + 25 output = 51 cycles.
- Inverse transform, for output lane (x,y), idx=x+5y:
  - src = y + 5*((2x+3y) mod 5).
  - out[idx] = rotr(in[src], R[idx]).
- Forward transform (INVERSE=0): out[y+5*((2x+3y) mod 5)] = rotl(in[x+5y], R[x+5y]).
- Rho offsets R[0..24]: 0,1,62,28,27, 36,44,6,55,20, 3,10,43,25,39, 41,45,15,21,8, 18,2,61,56,14.
- Frame errors:
  - frame_err pulses the cycle after an accepted beat where s_last != (in_cnt==24).
  - Counting still governs framing: s_last is advisory and never truncates or extends a frame.
- Simultaneous events: s_valid is ignored outside LOAD. m_ready is ignored outside SEND.

Decomposition:
- Package keccak_pkg:
  - LANES=25, LANE_W=64.
  - RHO_OFS[25] constant array.
  - Function pi_src(idx) returning the source index.
  - State enum {LOAD, XFORM, SEND}.
  - Shared with the RhoPi rework.
- Sub-module rhopi_inv_comb:
  - Purely combinational 25-lane transform with an INVERSE parameter.
  - Instantiated once between in_buf and out_buf; unit-testable on its own.

Test Plan:
- Lane 0 = 64'hDEADBEEF_01234567, others 0 -> out lane 0 = 64'hDEADBEEF_01234567; all other lanes 0; m_last only on beat 24.
- Lane 1 = 64'h1, others 0 -> out lane 6 = 64'h0000_0000_0010_0000 (rotr 44); all other lanes 0.
- Lane 10 = 64'h1, others 0 -> out lane 1 = 64'h8000_0000_0000_0000 (rotr 1).
- Round trip: random state -> RhoPi -> rhopi_inv_stream (INVERSE=1) -> output equals the original state for 1000 random states.
- Backpressure and errors:
  - Random s_valid/m_ready gaps -> m_data stable while stalled; no lane dropped or duplicated.
  - s_last at lane 10 -> frame_err pulses once; frame still completes at lane 24.
- Reset mid-frame: assert rst_n=0 in SEND at out_cnt=7 -> next cycle m_valid=0, s_ready=1; a fresh frame produces correct output from lane 0.

Source files
------------

// File: rtl/keccak_pkg.sv
// keccak_pkg: shared Keccak lane constants, rho offsets, pi index map and stream FSM states.
package keccak_pkg;
   localparam int LANES = 25;
   localparam int LANE_W = 64;
   localparam int RHO_OFS [LANES] = '{
      0, 1, 62, 28, 27,
      36, 44, 6, 55, 20,
      3, 10, 43, 25, 39,
      41, 45, 15, 21, 8,
      18, 2, 61, 56, 14
   };
   typedef enum logic [1:0] {LOAD, XFORM, SEND} state_t;
   // Lane index that pi moves into position idx=x+5y.
   function automatic int pi_src(input int idx);
      return idx / 5 + 5 * ((2 * (idx % 5) + 3 * (idx / 5)) % 5);
   endfunction
endpackage

// File: rtl/rhopi_inv_comb.sv
// rhopi_inv_comb: combinational 25-lane rho+pi transform, inverse (INVERSE=1) or forward (INVERSE=0).
module rhopi_inv_comb
   import keccak_pkg::*;
#(
   parameter bit INVERSE = 1'b1
) (
   input  logic [LANES-1:0][LANE_W-1:0] in_st,
   output logic [LANES-1:0][LANE_W-1:0] out_st
);
   // A zero offset shifts by the full width, which yields 0 and leaves the plain lane.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam int S = pi_src(i);
      localparam int R = RHO_OFS[i];
      if (INVERSE) begin : g_inv
         assign out_st[i] = (in_st[S] >> R) | (in_st[S] << (LANE_W - R));
      end else begin : g_fwd
         assign out_st[S] = (in_st[i] << R) | (in_st[i] >> (LANE_W - R));
      end
   end
endmodule

// File: rtl/rhopi_inv_stream.sv
// rhopi_inv_stream: lane-serial rho+pi (inverse by default); buffers 25 lanes, transforms in one cycle, streams out.
module rhopi_inv_stream
   import keccak_pkg::*;
#(
   parameter int LANE_W  = 64,
   parameter bit INVERSE = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [LANE_W-1:0] s_data,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [LANE_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic              frame_err
);
   state_t state, state_nxt;
   logic [4:0] in_cnt, out_cnt;
   logic [LANES-1:0][LANE_W-1:0] in_buf, out_buf, xf;
   logic s_fire, m_fire, in_end, out_end;
   rhopi_inv_comb #(.INVERSE(INVERSE)) u_xf (.in_st(in_buf), .out_st(xf));
   always_comb begin
      s_ready = state == LOAD;
      m_valid = state == SEND;
      busy = state != LOAD;
      s_fire = s_valid && s_ready;
      m_fire = m_valid && m_ready;
      in_end = in_cnt == 5'd24;
      out_end = out_cnt == 5'd24;
      m_data = m_valid ? out_buf[out_cnt] : '0;
      m_last = m_valid && out_end;
      state_nxt = state == XFORM ? SEND :
                  (s_fire && in_end) ? XFORM :
                  (m_fire && out_end) ? LOAD : state;
   end
   // s_last only flags disagreement; the lane count alone frames the state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= LOAD;
         in_cnt <= '0;
         out_cnt <= '0;
         in_buf <= '0;
         out_buf <= '0;
         frame_err <= 1'b0;
      end else begin
         state <= state_nxt;
         frame_err <= s_fire && (s_last != in_end);
         if (s_fire) begin
            in_buf[in_cnt] <= s_data;
            in_cnt <= in_end ? '0 : in_cnt + 5'd1;
         end
         if (state == XFORM) out_buf <= xf;
         if (m_fire) out_cnt <= out_end ? '0 : out_cnt + 5'd1;
      end
   end
endmodule
